m_mem_access: RTL and testbench

- M-stage memory access unit; it is the consumer of the E/M pipeline register outputs (address, store data, DM op, write enables, PC).
- Turns one M-stage load/store into a req/ack transaction on the data bus and drives mem_stall so the hazard unit freezes the pipeline until the access completes.
- Performs byte-enable generation, store-data lane replication and load-data alignment/extension.
- Sits between the E/M register and the M/W register, with the bus bridge / data memory on its other side.

---
 rtl/m_mem_access.sv | 124 ++++++++++++
 tb/tb_m_mem_access.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/m_mem_access.sv
// m_mem_access: M-stage load/store unit driving a req/ack data bus and the pipeline stall.
// Define MISALIGN_EXC_EN to raise address-error exceptions instead of issuing misaligned accesses.
module m_mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_load,
    input  logic        m_store,
    input  logic [1:0]  m_dm_op,
    input  logic        m_unsigned,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [31:0] m_pc,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_timeout,
    output logic        exc_adel,
    output logic        exc_ades
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        w_access, w_is_load, w_half, w_byte, w_mis, w_unused;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata, w_bsh, w_hsh, w_ldata;

    assign w_access  = m_valid & (m_load | m_store);
    assign w_is_load = m_load & ~m_store;
    assign w_half    = m_dm_op == 2'b01;
    assign w_byte    = m_dm_op == 2'b10;
    assign w_unused  = ^m_pc;

    assign w_byteen = w_byte ? 4'b0001 << m_addr[1:0] : w_half ? (m_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata  = w_byte ? {4{m_wdata[7:0]}} : w_half ? {2{m_wdata[15:0]}} : m_wdata;

    // Shift the addressed lane down to bit 0, then extend.
    assign w_bsh   = bus_rdata >> {m_addr[1:0], 3'b000};
    assign w_hsh   = bus_rdata >> {m_addr[1], 4'b0000};
    assign w_ldata = w_byte ? {{24{~m_unsigned & w_bsh[7]}}, w_bsh[7:0]}
                   : w_half ? {{16{~m_unsigned & w_hsh[15]}}, w_hsh[15:0]} : bus_rdata;

`ifdef MISALIGN_EXC_EN
    assign w_mis = w_half ? m_addr[0] : w_byte ? 1'b0 : |m_addr[1:0];
`else
    assign w_mis = 1'b0;
`endif

    assign mem_stall = (r_state == IDLE && w_access) || r_state == REQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_byteen  <= '0;
            bus_wdata   <= '0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            bus_timeout <= 1'b0;
            exc_adel    <= 1'b0;
            exc_ades    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    load_valid <= 1'b0;
                    load_data  <= '0;
                    exc_adel   <= 1'b0;
                    exc_ades   <= 1'b0;
                    if (w_access && w_mis) begin
                        exc_adel   <= w_is_load;
                        exc_ades   <= m_store;
                        load_valid <= w_is_load;
                        r_state    <= DONE;
                    end else if (w_access) begin
                        bus_req    <= 1'b1;
                        bus_we     <= m_store;
                        bus_addr   <= {m_addr[31:2], 2'b00};
                        bus_byteen <= w_byteen;
                        bus_wdata  <= w_wdata;
                        r_cnt      <= '0;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        load_data  <= w_is_load ? w_ldata : 32'd0;
                        load_valid <= w_is_load;
                        r_state    <= DONE;
                    end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        bus_req     <= 1'b0;
                        bus_timeout <= 1'b1;
                        load_data   <= '0;
                        load_valid  <= w_is_load;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE: begin
                    load_valid <= 1'b0;
                    load_data  <= '0;
                    exc_adel   <= 1'b0;
                    exc_ades   <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_mem_access.sv
// tb_m_mem_access: directed vectors for m_mem_access with TIMEOUT_CYCLES=4.
module tb_m_mem_access;
    logic        clk = 1'b0;
    logic        reset, m_valid, m_load, m_store, m_unsigned, bus_ack;
    logic [1:0]  m_dm_op;
    logic [31:0] m_addr, m_wdata, m_pc, bus_rdata;
    logic        bus_req, bus_we, mem_stall, load_valid, bus_timeout, exc_adel, exc_ades;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_byteen;
    int          n_chk = 0, n_err = 0;
    int          stalls, reqs;

    m_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_load(m_load), .m_store(m_store),
        .m_dm_op(m_dm_op), .m_unsigned(m_unsigned), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_pc(m_pc), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
        .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
        .bus_timeout(bus_timeout), .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one access at a negedge and steps until mem_stall falls (DONE cycle).
    // ack_at: REQ cycle on which bus_ack is raised (0 = never).
    task automatic run(input logic ld, input logic st, input logic [1:0] op, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int ack_at);
        @(negedge clk);
        m_valid = 1'b1; m_load = ld; m_store = st; m_dm_op = op; m_unsigned = uns;
        m_addr = a; m_wdata = wd; bus_rdata = rd; bus_ack = 1'b0;
        stalls = 0; reqs = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!mem_stall) break;
            stalls++;
            if (bus_req) begin
                reqs++;
                bus_ack = (reqs == ack_at);
            end
            @(negedge clk);
            bus_ack = 1'b0;
        end
    endtask

    // Leaves DONE: pipeline advances, checks the one-cycle load strobe dropped.
    task automatic finish_access(input string tag);
        @(negedge clk);
        m_valid = 1'b0;
        #1;
        chk({tag, "_lv_drop"}, {31'd0, load_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; m_valid = 1'b0; m_load = 1'b0; m_store = 1'b0; m_dm_op = 2'b00;
        m_unsigned = 1'b0; m_addr = '0; m_wdata = '0; m_pc = 32'h0040_0000; bus_ack = 1'b0;
        bus_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req", {31'd0, bus_req}, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_byteen", {28'd0, bus_byteen}, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_flags", {28'd0, load_valid, bus_timeout, exc_adel, exc_ades}, 0);
        chk("rst_stall", {31'd0, mem_stall}, 0);

        // Stray ack while idle must be ignored
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("stray_ack", {30'd0, bus_req, load_valid}, 0);

        // sw
        run(0, 1, 2'b00, 0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1);
        chk("sw_stall", stalls, 2);
        chk("sw_we", {31'd0, bus_we}, 1);
        chk("sw_addr", bus_addr, 32'h1004);
        chk("sw_byteen", {28'd0, bus_byteen}, 32'hF);
        chk("sw_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("sw_req_done", {31'd0, bus_req}, 0);
        chk("sw_lv", {31'd0, load_valid}, 0);
        finish_access("sw");

        // lb / lbu
        run(1, 0, 2'b10, 0, 32'h0000_2003, 32'h0, 32'h8011_2233, 1);
        chk("lb_we", {31'd0, bus_we}, 0);
        chk("lb_addr", bus_addr, 32'h2000);
        chk("lb_byteen", {28'd0, bus_byteen}, 32'h8);
        chk("lb_lv", {31'd0, load_valid}, 1);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        finish_access("lb");
        chk("lb_data_drop", load_data, 0);
        run(1, 0, 2'b10, 1, 32'h0000_2003, 32'h0, 32'h8011_2233, 1);
        chk("lbu_data", load_data, 32'h0000_0080);
        finish_access("lbu");

        // sh / lh / lhu, with a delayed ack
        run(0, 1, 2'b01, 0, 32'h0000_3002, 32'h0000_ABCD, 32'h0, 1);
        chk("sh_byteen", {28'd0, bus_byteen}, 32'hC);
        chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        finish_access("sh");
        run(1, 0, 2'b01, 0, 32'h0000_3002, 32'h0, 32'h7FFF_0001, 3);
        chk("lh_stall", stalls, 4);
        chk("lh_data", load_data, 32'h0000_7FFF);
        finish_access("lh");
        run(1, 0, 2'b01, 0, 32'h0000_3000, 32'h0, 32'h1234_8001, 1);
        chk("lh_lo_byteen", {28'd0, bus_byteen}, 32'h3);
        chk("lh_lo_data", load_data, 32'hFFFF_8001);
        finish_access("lh_lo");
        run(1, 0, 2'b01, 1, 32'h0000_3000, 32'h0, 32'h1234_8001, 1);
        chk("lhu_data", load_data, 32'h0000_8001);
        finish_access("lhu");

        // sb lane 1, and reserved op behaving as word (load+store -> store wins)
        run(0, 1, 2'b10, 0, 32'h0000_5001, 32'h0000_00A5, 32'h0, 1);
        chk("sb_byteen", {28'd0, bus_byteen}, 32'h2);
        chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        finish_access("sb");
        run(1, 1, 2'b11, 0, 32'h0000_6008, 32'h1122_3344, 32'h0, 1);
        chk("res_we", {31'd0, bus_we}, 1);
        chk("res_byteen", {28'd0, bus_byteen}, 32'hF);
        chk("res_wdata", bus_wdata, 32'h1122_3344);
        finish_access("res");

        // Misaligned word load
        run(1, 0, 2'b00, 0, 32'h0000_4001, 32'h0, 32'h1234_5678, 1);
`ifdef MISALIGN_EXC_EN
        chk("mis_stall", stalls, 1);
        chk("mis_reqs", reqs, 0);
        chk("mis_adel", {31'd0, exc_adel}, 1);
        chk("mis_data", load_data, 0);
        finish_access("mis");
        chk("mis_adel_drop", {31'd0, exc_adel}, 0);
`else
        chk("mis_stall", stalls, 2);
        chk("mis_addr", bus_addr, 32'h4000);
        chk("mis_data", load_data, 32'h1234_5678);
        chk("mis_adel", {31'd0, exc_adel}, 0);
        finish_access("mis");
`endif

        // Timeout: no ack for a load
        run(1, 0, 2'b00, 0, 32'h0000_7000, 32'h0, 32'hCAFE_F00D, 0);
        chk("to_reqs", reqs, 4);
        chk("to_stall", stalls, 5);
        chk("to_req", {31'd0, bus_req}, 0);
        chk("to_flag", {31'd0, bus_timeout}, 1);
        chk("to_data", load_data, 0);
        finish_access("to");
        chk("to_sticky", {31'd0, bus_timeout}, 1);

        // Reset in REQ cycle 2 coinciding with ack
        @(negedge clk);
        m_valid = 1'b1; m_load = 1'b1; m_store = 1'b0; m_dm_op = 2'b00; m_addr = 32'h8000;
        bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        #1;
        chk("rr_req1", {31'd0, bus_req}, 1);
        @(negedge clk);
        reset = 1'b1; bus_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus_ack = 1'b0; m_valid = 1'b0;
        #1;
        chk("rr_req", {31'd0, bus_req}, 0);
        chk("rr_stall", {31'd0, mem_stall}, 0);
        chk("rr_lv", {31'd0, load_valid}, 0);
        chk("rr_ld", load_data, 0);
        chk("rr_to", {31'd0, bus_timeout}, 0);
        @(negedge clk);
        #1;
        chk("rr_lv2", {31'd0, load_valid}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
